// File: rtl/prog_ram_sequencer.sv
// rtl/prog_ram_sequencer.sv - program RAM port arbiter and run controller
module prog_ram_sequencer #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = 16'h3c00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              run,
    input  logic              abort,
    input  logic [ADDR_W-1:0] proc_pc,
    input  logic              proc_read_en,
    output logic [DATA_W-1:0] proc_data,
    output logic              proc_start,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              halted,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t state;
    state_t state_next;
    logic   run_pending;
    logic   fetch_valid_d;
    logic   halt_hit;
    logic   in_run;

    assign in_run     = (state == S_RUN);
    assign halt_hit   = fetch_valid_d && (ram_dout == HALT_WORD);
    assign host_gnt   = host_req && !in_run;
    assign host_rdata = host_rvalid ? ram_dout : '0;
    assign proc_data  = ram_dout;

    // Abort outranks halt detection so an aborted run never reports halted.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_HALTED: begin
                if (run_pending && !host_req) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (halt_hit) begin
                    state_next = S_HALTED;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ram_read_en  = 1'b0;
        ram_write_en = 1'b0;
        ram_addr     = '0;
        ram_din      = '0;
        if (in_run) begin
            ram_read_en = proc_read_en;
            ram_addr    = proc_pc;
        end else if (host_req) begin
            ram_read_en  = !host_we;
            ram_write_en = host_we;
            ram_addr     = host_addr;
            ram_din      = host_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            run_pending   <= 1'b0;
            fetch_valid_d <= 1'b0;
            host_rvalid   <= 1'b0;
            proc_start    <= 1'b0;
            halted        <= 1'b0;
            cycle_count   <= '0;
        end else begin
            state         <= state_next;
            host_rvalid   <= host_gnt && !host_we;
            fetch_valid_d <= in_run && proc_read_en;
            if (!in_run) begin
                if (state_next == S_RUN) begin
                    run_pending <= 1'b0;
                    cycle_count <= '0;
                    halted      <= 1'b0;
                    proc_start  <= 1'b1;
                end else if (run) begin
                    run_pending <= 1'b1;
                end
            end else begin
                if (cycle_count != 32'hFFFF_FFFF) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if (state_next != S_RUN) begin
                    proc_start <= 1'b0;
                    halted     <= (state_next == S_HALTED);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_ram_sequencer.sv
// tb/tb_prog_ram_sequencer.sv - scoreboard bench for prog_ram_sequencer
module tb_prog_ram_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [9:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_gnt;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  proc_pc;
    logic        proc_read_en;
    logic [15:0] proc_data;
    logic        proc_start;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [9:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout = '0;
    logic        halted;
    logic [31:0] cycle_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        h;
        logic [31:0] cnt;
        int          cyc;
    } end_t;

    logic [15:0] rd_q[$];
    end_t        end_q[$];

    logic [15:0] mem [0:1023];
    logic [9:0]  pc = '0;

    always #5 clk = ~clk;

    prog_ram_sequencer dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .run(run), .abort(abort),
        .proc_pc(proc_pc), .proc_read_en(proc_read_en), .proc_data(proc_data),
        .proc_start(proc_start), .ram_read_en(ram_read_en),
        .ram_write_en(ram_write_en), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .halted(halted), .cycle_count(cycle_count)
    );

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_din;
        if (ram_read_en) ram_dout <= mem[ram_addr];
    end

    // Processor model: fetches pc 0,1,2,... every cycle while started.
    always @(posedge clk) pc <= proc_start ? pc + 10'd1 : 10'd0;
    assign proc_pc      = pc;
    assign proc_read_en = proc_start;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic prev_start = 1'b0;
    int   run_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
            run_cyc    = 0;
        end else begin
            if (host_rvalid) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rvalid_unexpected: got rdata %h expected no rvalid", host_rdata);
                end else begin
                    chk("host_rdata", host_rdata, rd_q.pop_front());
                end
            end
            if (proc_start) run_cyc++;
            if (prev_start && !proc_start) begin
                if (end_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL run_end_unexpected: got run end expected none");
                end else begin
                    end_t e;
                    e = end_q.pop_front();
                    chk("end_halted", halted, e.h);
                    chk("end_cycle_count", cycle_count, e.cnt);
                    chk("end_start_cycles", run_cyc, e.cyc);
                end
                run_cyc = 0;
            end
            prev_start = proc_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [9:0] a, input logic [15:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        chk("gnt_write", host_gnt, 1'b1);
        tick();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [9:0] a, input logic [15:0] exp);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        rd_q.push_back(exp);
        @(negedge clk);
        chk("gnt_read", host_gnt, 1'b1);
        tick();
        host_req = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic push_end(input logic h, input logic [31:0] cnt, input int cyc);
        end_t e;
        e.h = h; e.cnt = cnt; e.cyc = cyc;
        end_q.push_back(e);
    endtask

    // Returns one ns into the second RUN cycle.
    task automatic wait_start();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (proc_start) seen = 1;
        end
        if (!seen) chk("wait_start_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_stop();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (!proc_start) seen = 1;
        end
        if (!seen) chk("wait_stop_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_proc_start", proc_start, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_rvalid", host_rvalid, 1'b0);
        chk("rst_gnt", host_gnt, 1'b0);
        tick();

        host_write(10'd0, 16'h1111);
        host_write(10'd1, 16'h2222);
        host_write(10'd2, 16'h3333);
        host_write(10'd3, 16'h3c00);
        host_read(10'd0, 16'h1111);
        host_read(10'd1, 16'h2222);
        host_read(10'd2, 16'h3333);
        host_read(10'd3, 16'h3c00);
        repeat (2) tick();

        // Run to halt with the host held off from the second RUN cycle.
        push_end(1'b1, 32'd5, 5);
        pulse_run();
        wait_start();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_gnt", host_gnt, (k == 4));
        end
        rd_q.push_back(16'h3333);
        tick();
        host_req = 1'b0;
        wait_stop();

        // Run pulse during three host reads: host wins every tie.
        push_end(1'b1, 32'd5, 5);
        run = 1'b1;
        host_read(10'd0, 16'h1111);
        run = 1'b0;
        host_read(10'd1, 16'h2222);
        host_read(10'd2, 16'h3333);
        @(negedge clk);
        chk("tie_not_started", proc_start, 1'b0);
        @(negedge clk);
        chk("tie_started", proc_start, 1'b1);
        chk("tie_halted_clr", halted, 1'b0);
        chk("tie_count_clr", cycle_count, 32'd0);
        tick();
        wait_stop();

        // Abort on the 10th RUN cycle of a program without a halt word.
        host_write(10'd3, 16'h4444);
        push_end(1'b0, 32'd10, 10);
        pulse_run();
        wait_start();
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_count_held", cycle_count, 32'd10);
        chk("abort_idle", proc_start, 1'b0);
        tick();

        // Abort coincident with halt detection; abort in IDLE keeps the run request.
        host_write(10'd3, 16'h3c00);
        push_end(1'b0, 32'd5, 5);
        run = 1'b1; abort = 1'b1;
        tick();
        run = 1'b0; abort = 1'b0;
        wait_start();
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_stop();
        @(negedge clk);
        chk("abort_halt_halted", halted, 1'b0);
        tick();

        // Asynchronous reset mid-run, then a normal run afterwards.
        pulse_run();
        wait_start();
        repeat (2) tick();
        #3 reset = 1'b1;
        #1;
        chk("midrst_proc_start", proc_start, 1'b0);
        chk("midrst_halted", halted, 1'b0);
        chk("midrst_cycle_count", cycle_count, 32'd0);
        chk("midrst_rvalid", host_rvalid, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        push_end(1'b1, 32'd5, 5);
        pulse_run();
        wait_start();
        wait_stop();
        @(negedge clk);
        chk("post_rst_halted", halted, 1'b1);

        repeat (3) @(negedge clk);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        chk("end_q_drained", end_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_ram_sequencer.md
# prog_ram_sequencer

Run controller and arbiter for the 16x1024 program RAM. It shares the single RAM port between a host loader and the processor's instruction-fetch path. It drives the processor's `start`, stops execution when the halt word is fetched, and reports halt status and the run-cycle count. It sits between the host/loader logic, the program RAM and the processor.

## Interface
- ADDR_W, 10, program RAM address width
- DATA_W, 16, program RAM word width
- HALT_WORD, 16'h3c00, instruction word that ends a run
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- host_req  in  1  host requests one RAM access this cycle
- host_we  in  1  1 = write, 0 = read (qualified by host_req)
- host_addr  in  ADDR_W  host access address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access performed this cycle (combinational)
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid (one cycle after a granted read)
- run  in  1  pulse, request program execution
- abort  in  1  pulse, force-stop a run
- proc_pc  in  ADDR_W  processor fetch address
- proc_read_en  in  1  processor fetch request
- proc_data  out  DATA_W  fetched instruction to processor (= ram_dout)
- proc_start  out  1  processor run enable (registered)
- ram_read_en, ram_write_en  out  1  RAM port enables
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, 1-cycle registered latency
- halted  out  1  last run ended on HALT_WORD; cleared on next run entry
- cycle_count  out  32  cycles spent in RUN in the current or last run

## Operation
- States: IDLE, RUN, HALTED. All outputs reset to 0; state resets to IDLE; run_pending resets to 0.
- **IDLE and HALTED (host owns RAM)**
  - host_gnt = host_req.
  - Write: ram_write_en=1, ram_addr=host_addr, ram_din=host_wdata.
  - Read: ram_read_en=1; host_rvalid=1 on the next cycle with host_rdata=ram_dout.
- **Starting a run**
  - A run pulse in IDLE or HALTED sets run_pending.
  - The transition to RUN happens on the first edge where run_pending=1 and host_req=0, so the host always wins a tie.
  - Entering RUN: run_pending cleared, cycle_count cleared to 0, halted cleared, proc_start set to 1.
- **RUN (processor owns RAM)**
  - host_gnt=0. Host requests are held off with no RAM activity, and run pulses are ignored.
  - ram_read_en=proc_read_en, ram_addr=proc_pc, ram_write_en=0.
  - fetch_valid_d is proc_read_en delayed one cycle.
  - If fetch_valid_d=1 and ram_dout==HALT_WORD: next state is HALTED, halted=1, proc_start=0.
  - cycle_count increments every cycle state==RUN, including the halt-detect cycle, and saturates at 32'hFFFF_FFFF.
- **Abort**
  - abort in RUN: next state IDLE, proc_start=0, halted stays 0, cycle_count holds.
  - abort in IDLE or HALTED: ignored. It does not clear run_pending.
- **Simultaneous events in RUN**
  - abort and halt detection in the same cycle: abort wins, next state IDLE, halted=0.
- **Reset**
  - Reset at any time, including mid-run, returns immediately (asynchronously) to IDLE with all outputs 0.
  - A pending host read's rvalid is dropped.

## Timing
- Host write: committed at the edge ending the grant cycle.
- Host read: data at grant+1 (host_rvalid for exactly 1 cycle).
- Run start: run pulse at edge E (host_req=0) gives state=RUN and proc_start=1 after E+1. It is later if host_req is held high.
- Halt: fetch of HALT_WORD issued in cycle N; detected in N+1; state=HALTED and proc_start=0 from N+2.
  - Fetches issued in N+1 are still serviced; their results are discarded.
- proc_data is combinational from ram_dout in every state.
- No combinational path from host inputs to the processor-side outputs, or from processor inputs to the host-side outputs.

## Test plan
- Load and readback:
  - Stimulus: host writes 16'h1111, 16'h2222, 16'h3333, 16'h3c00 to addr 0..3, then reads them back.
  - Required: host_gnt=1 each cycle; each host_rdata matches the written word one cycle after its read; host_rvalid is a 1-cycle pulse.
- Run to halt:
  - Stimulus: after loading, pulse run. The processor model fetches pc 0,1,2,3,... with read_en=1 every cycle.
  - Required: proc_start=1 for exactly 5 cycles, then state HALTED with halted=1 and cycle_count=5.
- Host held off during RUN:
  - Stimulus: hold host_req=1 (read, addr 2) from the 2nd RUN cycle.
  - Required: host_gnt=0 until HALTED; then the grant is given and host_rdata=16'h3333 on the next cycle.
- Run/host tie:
  - Stimulus: pulse run while host_req=1 for 3 cycles.
  - Required: all 3 host accesses are granted; RUN is entered on the edge after host_req drops.
- Abort:
  - Stimulus: program with no HALT_WORD; abort on the 10th RUN cycle.
  - Required: state IDLE, halted=0, cycle_count=10, proc_start=0 on the next cycle.
  - Stimulus: abort in the same cycle as halt detection.
  - Required: state IDLE, halted=0.
- Reset mid-run:
  - Stimulus: assert reset during RUN.
  - Required: proc_start, halted, cycle_count and host_rvalid go to 0 immediately; state IDLE; a run pulse after reset works normally.
